// File: rtl/chebyshev_accumulator.sv
// ----------------------------------------------------------------------------
// chebyshev_accumulator
//   Sums N_TERMS consecutive signed terms from the upstream product stage into
//   one polynomial result. The accumulator has GUARD extra bits and can either
//   saturate or wrap when an addition overflows. The result sits in a
//   valid/ready output register, and upstream is stalled while it is held.
// ----------------------------------------------------------------------------
`default_nettype none

module chebyshev_accumulator #(
  parameter int IN_W    = 12,
  parameter int N_TERMS = 4,
  parameter int GUARD   = 2,
  parameter int SAT     = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       term_valid,
  input  logic [IN_W-1:0]            term_in,
  output logic                       term_ready,
  output logic [$clog2(N_TERMS)-1:0] term_idx,
  output logic                       sum_valid,
  output logic [IN_W+GUARD-1:0]      sum_out,
  input  logic                       sum_ready,
  output logic                       overflow
);

  localparam int OUT_W = IN_W + GUARD;
  localparam int IDX_W = $clog2(N_TERMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);
  localparam logic [OUT_W-1:0] SAT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [OUT_W-1:0] acc;
  logic             ovf_flag;
  logic             accept;
  logic             final_term;
  logic [OUT_W:0]   sum_wide;
  logic             this_ovf;
  logic [OUT_W-1:0] acc_next;

  // One extra bit: overflow shows up as disagreement between the top two bits.
  always_comb begin
    sum_wide = {acc[OUT_W-1], acc} + {{(GUARD+1){term_in[IN_W-1]}}, term_in};
    this_ovf = sum_wide[OUT_W] ^ sum_wide[OUT_W-1];
    acc_next = sum_wide[OUT_W-1:0];
    if (SAT != 0 && this_ovf) begin
      acc_next = sum_wide[OUT_W] ? SAT_MIN : SAT_MAX;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next state, term handshake and frame-end decode.
  always_comb begin
    state_next = state;
    term_ready = (state == ST_ACC);
    accept     = 1'b0;
    final_term = 1'b0;
    if (clear) begin
      state_next = ST_ACC;
    end else begin
      case (state)
        ST_ACC: begin
          if (term_valid) begin
            accept     = 1'b1;
            final_term = (term_idx == LAST_IDX);
            if (term_idx == LAST_IDX) begin
              state_next = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (sum_ready) begin
            state_next = ST_ACC;
          end
        end
        default: state_next = ST_ACC;
      endcase
    end
  end

  // Accumulator, term counter and held result; clear outranks everything.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc       <= '0;
      term_idx  <= '0;
      ovf_flag  <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      term_idx  <= '0;
      ovf_flag  <= 1'b0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      if (final_term) begin
        sum_out   <= acc_next;
        overflow  <= ovf_flag | this_ovf;
        sum_valid <= 1'b1;
        acc       <= '0;
        term_idx  <= '0;
        ovf_flag  <= 1'b0;
      end else begin
        acc      <= acc_next;
        term_idx <= term_idx + IDX_W'(1);
        ovf_flag <= ovf_flag | this_ovf;
      end
    end else if (state == ST_HOLD && sum_ready) begin
      sum_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chebyshev_accumulator.sv
// ----------------------------------------------------------------------------
// tb_chebyshev_accumulator
//   Three accumulators share one stimulus stream: the default build, and
//   GUARD=0 builds with saturation and with wrap. A reference model pushes
//   expected frame sums into a scoreboard; a monitor on the falling edge
//   checks handshakes and pops results as they are consumed or dropped.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_chebyshev_accumulator;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        clear = 1'b0;
  logic        term_valid = 1'b0;
  logic [11:0] term_in = '0;
  logic        sum_ready = 1'b0;

  logic        tr0, tr1, tr2;
  logic [1:0]  idx0, idx1, idx2;
  logic        sv0, sv1, sv2;
  logic [13:0] so0;
  logic [11:0] so1, so2;
  logic        ov0, ov1, ov2;

  always #5 clock = ~clock;

  chebyshev_accumulator #(.IN_W(12), .N_TERMS(4), .GUARD(2), .SAT(1)) u_dut (
    .clock(clock), .resetn(resetn), .clear(clear), .term_valid(term_valid),
    .term_in(term_in), .term_ready(tr0), .term_idx(idx0), .sum_valid(sv0),
    .sum_out(so0), .sum_ready(sum_ready), .overflow(ov0));

  chebyshev_accumulator #(.IN_W(12), .N_TERMS(4), .GUARD(0), .SAT(1)) u_g0_sat (
    .clock(clock), .resetn(resetn), .clear(clear), .term_valid(term_valid),
    .term_in(term_in), .term_ready(tr1), .term_idx(idx1), .sum_valid(sv1),
    .sum_out(so1), .sum_ready(sum_ready), .overflow(ov1));

  chebyshev_accumulator #(.IN_W(12), .N_TERMS(4), .GUARD(0), .SAT(0)) u_g0_wrap (
    .clock(clock), .resetn(resetn), .clear(clear), .term_valid(term_valid),
    .term_in(term_in), .term_ready(tr2), .term_idx(idx2), .sum_valid(sv2),
    .sum_out(so2), .sum_ready(sum_ready), .overflow(ov2));

  typedef struct {
    longint s0, s1, s2;
    bit     o0, o1, o2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   frames_done = 0;
  bit   m_busy = 1'b0;
  int   m_cnt = 0;
  int   frame[4];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame sum by plain integer arithmetic: after each addition the running
  // value is clamped (sat) or folded back by one range (wrap) if it left the
  // w-bit signed range.
  function automatic void ref_sum(input int t[4], input int w, input bit sat,
                                  output longint s, output bit ovf);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    s = 0;
    ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = s + t[i];
      if (s > hi || s < lo) begin
        ovf = 1'b1;
        if (sat) s = (s > hi) ? hi : lo;
        else     s = (s > hi) ? s - (longint'(1) << w) : s + (longint'(1) << w);
      end
    end
  endfunction

  // Reference model of the frame protocol, advanced on every rising edge.
  always @(posedge clock or negedge resetn) begin
    exp_t e;
    if (!resetn) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      sb.delete();
    end else if (clear) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      if (sum_ready) begin
        m_busy = 1'b0;
        frames_done++;
      end
    end else if (term_valid) begin
      frame[m_cnt] = int'($signed(term_in));
      m_cnt++;
      if (m_cnt == 4) begin
        ref_sum(frame, 14, 1'b1, e.s0, e.o0);
        ref_sum(frame, 12, 1'b1, e.s1, e.o1);
        ref_sum(frame, 12, 1'b0, e.s2, e.o2);
        sb.push_back(e);
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  // Monitor: handshake outputs against the model, held results against the
  // scoreboard head; pop when the result is consumed or flushed.
  always @(negedge clock) begin
    exp_t e;
    if (resetn) begin
      check("term_ready", tr0, !m_busy);
      check("term_ready_g0s", tr1, !m_busy);
      check("term_ready_g0w", tr2, !m_busy);
      check("term_idx", idx0, m_cnt);
      check("term_idx_g0w", idx2, m_cnt);
      check("sum_valid", sv0, m_busy);
      check("sum_valid_g0s", sv1, m_busy);
      check("sum_valid_g0w", sv2, m_busy);
      if (m_busy) begin
        check("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb[0];
          check("sum_out", longint'($signed(so0)), e.s0);
          check("overflow", ov0, e.o0);
          check("sum_out_g0s", longint'($signed(so1)), e.s1);
          check("overflow_g0s", ov1, e.o1);
          check("sum_out_g0w", longint'($signed(so2)), e.s2);
          check("overflow_g0w", ov2, e.o2);
          if (clear || sum_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Apply one cycle of inputs just after a rising edge; return after the next.
  task automatic drive(input bit tv, input int t, input bit sr, input bit clr);
    term_valid = tv;
    term_in    = 12'(t);
    sum_ready  = sr;
    clear      = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    term_valid = 1'b0;
    clear      = 1'b0;
    resetn     = 1'b0;
    #1;
    check({tag, "_sum_valid"}, sv0, 0);
    check({tag, "_sum_out"}, so0, 0);
    check({tag, "_overflow"}, ov0, 0);
    check({tag, "_term_idx"}, idx0, 0);
    check({tag, "_term_ready"}, tr0, 1);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int cyc;
    int target;
    int t;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_sum_valid", sv0, 0);
    check("rst_sum_out", so0, 0);
    check("rst_overflow", ov0, 0);
    check("rst_term_idx", idx0, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("rst_term_ready", tr0, 1);

    // Basic frame, result consumed at once.
    drive(1, 10, 1, 0);
    drive(1, -3, 1, 0);
    drive(1, 100, 1, 0);
    drive(1, 5, 1, 0);
    check("t1_sum", longint'($signed(so0)), 112);
    check("t1_valid", sv0, 1);
    check("t1_ovf", ov0, 0);
    check("t1_ready_low", tr0, 0);
    drive(0, 0, 1, 0);
    check("t1_ready_back", tr0, 1);

    // Most negative terms, result held under back-pressure.
    repeat (4) drive(1, -2048, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", sv0, 1);
      check("t2_hold_sum", longint'($signed(so0)), -8192);
      check("t2_hold_ovf", ov0, 0);
      check("t2_hold_ready", tr0, 0);
      drive(0, 0, 0, 0);
    end
    drive(0, 0, 1, 0);
    check("t2_released", sv0, 0);

    // Overflow: GUARD=0 saturating vs wrapping builds.
    drive(1, 2047, 1, 0);
    drive(1, 2047, 1, 0);
    drive(1, -5, 1, 0);
    drive(1, 1, 1, 0);
    check("t3_sat_sum", longint'($signed(so1)), 2043);
    check("t3_sat_ovf", ov1, 1);
    check("t3_wrap_sum", longint'($signed(so2)), -6);
    check("t3_wrap_ovf", ov2, 1);
    check("t3_wide_sum", longint'($signed(so0)), 4090);
    drive(0, 0, 1, 0);

    // Clear mid-frame with a valid term present.
    drive(1, 7, 1, 0);
    drive(1, 7, 1, 0);
    check("t4_idx_before_clear", idx0, 2);
    drive(1, 99, 1, 1);
    check("t4_idx_after_clear", idx0, 0);
    repeat (4) drive(1, 1, 1, 0);
    check("t4_sum", longint'($signed(so0)), 4);
    drive(0, 0, 1, 0);

    // Async reset mid-frame and while a result is held.
    repeat (3) drive(1, 9, 1, 0);
    pulse_reset("t5a");
    repeat (4) drive(1, 50, 0, 0);
    drive(0, 0, 0, 0);
    pulse_reset("t5b");
    drive(1, 1, 1, 0);
    drive(1, 2, 1, 0);
    drive(1, 3, 1, 0);
    drive(1, 4, 1, 0);
    check("t5_sum", longint'($signed(so0)), 10);
    drive(0, 0, 1, 0);

    // Random frames with bubbles, back-pressure and occasional clears.
    target = frames_done + 1000;
    cyc = 0;
    while (frames_done < target && cyc < 60000) begin
      case ($urandom % 5)
        0:       t = 2047;
        1:       t = -2048;
        default: t = int'($signed(12'($urandom)));
      endcase
      drive(($urandom % 10) < 7, t, ($urandom % 2) == 0, ($urandom % 150) == 0);
      cyc++;
    end
    if (frames_done < target) check("random_frames_done", frames_done, target);

    repeat (3) drive(0, 0, 1, 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
